// File: rtl/temp_servo_shutdown_ramp_if.sv
// Heater-drive bundle between the PID, the shutdown ramp and the PWM/DAC driver.
// master drives the run request, interlock, PID duty and ramp step.
interface temp_servo_shutdown_ramp_if #(
  parameter int SIGSIZE = 18,
  parameter int FRAC    = 24
);
  logic                       on;
  logic                       abort;
  logic signed [SIGSIZE-1:0]  duty_in;
  logic [SIGSIZE+FRAC-1:0]    step;
  logic                       PID_EN;
  logic [SIGSIZE-1:0]         duty_out;
  logic                       busy;
  logic                       done;

  modport master (
    output on, abort, duty_in, step,
    input  PID_EN, duty_out, busy, done
  );

  modport slave (
    input  on, abort, duty_in, step,
    output PID_EN, duty_out, busy, done
  );
endinterface

// File: rtl/temp_servo_shutdown_ramp.sv
// Bumpless heater turn-off: PID pass-through while on, then a linear
// fixed-point ramp of the last duty down to zero once on drops.
module temp_servo_shutdown_ramp #(
  parameter int SIGSIZE = 18,
  parameter int FRAC    = 24
) (
  input logic                       clk,
  input logic                       rst_n,
  temp_servo_shutdown_ramp_if.slave bus
);
  localparam int W = SIGSIZE + FRAC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RAMP = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state;
  logic [W-1:0]       acc;
  logic [SIGSIZE-1:0] duty_clamp;
  logic [W-1:0]       acc_cap;
  logic [W-1:0]       acc_dec;
  logic               ramp_end;

  assign duty_clamp = bus.duty_in[SIGSIZE-1] ? '0
                    : $unsigned(bus.duty_in);
  assign acc_cap    = {duty_clamp, {FRAC{1'b0}}};
  assign acc_dec    = acc - bus.step;
  // zero step means "drop now"; acc <= step also stops underflow
  assign ramp_end   = (bus.step == '0) || (acc <= bus.step);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      acc          <= '0;
      bus.PID_EN   <= 1'b0;
      bus.duty_out <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
    end else if (bus.abort) begin
      acc          <= '0;
      bus.PID_EN   <= 1'b0;
      bus.duty_out <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= (state == RAMP);
      state        <= (state == RAMP) ? DONE : IDLE;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          if (bus.on) begin
            state        <= RUN;
            bus.PID_EN   <= 1'b1;
            bus.duty_out <= duty_clamp;
          end else begin
            bus.PID_EN   <= 1'b0;
            bus.duty_out <= '0;
          end
        end
        RUN: begin
          bus.duty_out <= duty_clamp;
          if (bus.on) begin
            bus.PID_EN <= 1'b1;
          end else begin
            state      <= RAMP;
            acc        <= acc_cap;
            bus.PID_EN <= 1'b0;
            bus.busy   <= 1'b1;
          end
        end
        RAMP: begin
          if (bus.on) begin
            state        <= RUN;
            acc          <= '0;
            bus.PID_EN   <= 1'b1;
            bus.busy     <= 1'b0;
            bus.duty_out <= duty_clamp;
          end else if (ramp_end) begin
            state        <= DONE;
            acc          <= '0;
            bus.duty_out <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b1;
          end else begin
            acc          <= acc_dec;
            bus.duty_out <= acc_dec[W-1:FRAC];
          end
        end
        DONE: begin
          state        <= IDLE;
          bus.done     <= 1'b0;
          bus.busy     <= 1'b0;
          bus.PID_EN   <= 1'b0;
          bus.duty_out <= '0;
        end
        default: begin
          state        <= IDLE;
          acc          <= '0;
          bus.PID_EN   <= 1'b0;
          bus.duty_out <= '0;
          bus.busy     <= 1'b0;
          bus.done     <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_temp_servo_shutdown_ramp.sv
// Scoreboard bench for the heater shutdown ramp: pass-through, ramp
// profiles, restart, abort, zero step and async reset.
module tb_temp_servo_shutdown_ramp;
  localparam int SIGSIZE = 18;
  localparam int FRAC    = 24;
  localparam logic [41:0] S24 = 42'd16777216;
  localparam logic [41:0] S23 = 42'd8388608;

  typedef struct packed {
    logic               on;
    logic               abort;
    logic signed [17:0] din;
    logic [41:0]        stp;
  } stim_t;

  typedef struct packed {
    logic [17:0] duty;
    logic        pid;
    logic        busy;
    logic        done;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  temp_servo_shutdown_ramp_if #(.SIGSIZE(SIGSIZE), .FRAC(FRAC)) bus();

  temp_servo_shutdown_ramp #(.SIGSIZE(SIGSIZE), .FRAC(FRAC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input stim_t s);
    bus.on      = s.on;
    bus.abort   = s.abort;
    bus.duty_in = s.din;
    bus.step    = s.stp;
  endtask

  function automatic stim_t sm(input bit on, input bit ab,
                               input int din, input logic [41:0] s);
    sm = {on, ab, 18'(din), s};
  endfunction

  function automatic exp_t mk(input longint d, input bit p,
                              input bit b, input bit dn);
    mk = {18'(d), p, b, dn};
  endfunction

  function automatic exp_t sample();
    sample = {bus.duty_out, bus.PID_EN, bus.busy, bus.done};
  endfunction

  function automatic string fmt(input exp_t v);
    return $sformatf("duty=%0d pid=%b busy=%b done=%b",
                     v.duty, v.pid, v.busy, v.done);
  endfunction

  task automatic test_reset();
    exp_t e, o;
    rst_n = 1'b0;
    drive(sm(1, 0, 5000, S24));
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(mk(0, 0, 0, 0));
    e = exp_q.pop_front(); o = sample(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL reset_hold: got %s, want %s", fmt(o), fmt(e));
    end
    rst_n = 1'b1;
    exp_q.push_back(mk(5000, 1, 0, 0));
    tick();
    e = exp_q.pop_front(); o = sample(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL reset_release: got %s, want %s", fmt(o), fmt(e));
    end
  endtask

  task automatic test_passthrough();
    stim_t st[$]; exp_t ex[$]; exp_t e, o;
    st.push_back(sm(1, 0, -20, S24));    ex.push_back(mk(0, 1, 0, 0));
    st.push_back(sm(1, 0, 1234, S24));   ex.push_back(mk(1234, 1, 0, 0));
    st.push_back(sm(1, 0, 100000, S24)); ex.push_back(mk(100000, 1, 0, 0));
    st.push_back(sm(1, 0, -131072, S24)); ex.push_back(mk(0, 1, 0, 0));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]); exp_q.push_back(ex[i]); tick();
      e = exp_q.pop_front(); o = sample(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL pass[%0d]: got %s, want %s", i, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_ramp();
    longint unsigned dv[2] = '{100, 7};
    longint unsigned sv[2] = '{64'd16777216, 64'd12582912};
    for (int p = 0; p < 2; p++) begin
      stim_t st[$]; exp_t ex[$]; exp_t e, o;
      longint unsigned d = dv[p];
      longint unsigned s = sv[p];
      longint unsigned n = ((d << FRAC) + s - 1) / s;
      st.push_back(sm(1, 0, int'(d), 42'(s))); ex.push_back(mk(d, 1, 0, 0));
      st.push_back(sm(0, 0, int'(d), 42'(s))); ex.push_back(mk(d, 0, 1, 0));
      for (longint unsigned k = 1; k < n; k++) begin
        st.push_back(sm(0, 0, int'(d), 42'(s)));
        ex.push_back(mk(((d << FRAC) - k * s) >> FRAC, 0, 1, 0));
      end
      st.push_back(sm(0, 0, int'(d), 42'(s))); ex.push_back(mk(0, 0, 0, 1));
      st.push_back(sm(0, 0, int'(d), 42'(s))); ex.push_back(mk(0, 0, 0, 0));
      for (int i = 0; i < st.size(); i++) begin
        drive(st[i]); exp_q.push_back(ex[i]); tick();
        e = exp_q.pop_front(); o = sample(); checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL ramp%0d[%0d]: got %s, want %s",
                   p, i, fmt(o), fmt(e));
        end
      end
    end
  endtask

  task automatic test_fractional();
    int dseq[6] = '{3, 2, 2, 1, 1, 0};
    stim_t st[$]; exp_t ex[$]; exp_t e, o;
    st.push_back(sm(1, 0, 3, S23)); ex.push_back(mk(3, 1, 0, 0));
    for (int k = 0; k < 6; k++) begin
      st.push_back(sm(0, 0, 3, S23)); ex.push_back(mk(dseq[k], 0, 1, 0));
    end
    st.push_back(sm(0, 0, 3, S23)); ex.push_back(mk(0, 0, 0, 1));
    st.push_back(sm(0, 0, 3, S23)); ex.push_back(mk(0, 0, 0, 0));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]); exp_q.push_back(ex[i]); tick();
      e = exp_q.pop_front(); o = sample(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL frac[%0d]: got %s, want %s", i, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_restart();
    stim_t st[$]; exp_t ex[$]; exp_t e, o;
    st.push_back(sm(1, 0, 100, S24)); ex.push_back(mk(100, 1, 0, 0));
    for (int k = 0; k < 10; k++) begin
      st.push_back(sm(0, 0, 100, S24)); ex.push_back(mk(100 - k, 0, 1, 0));
    end
    st.push_back(sm(1, 0, 777, S24)); ex.push_back(mk(777, 1, 0, 0));
    st.push_back(sm(1, 0, 778, S24)); ex.push_back(mk(778, 1, 0, 0));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]); exp_q.push_back(ex[i]); tick();
      e = exp_q.pop_front(); o = sample(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL restart[%0d]: got %s, want %s", i, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_abort();
    stim_t st[$]; exp_t ex[$]; exp_t e, o;
    st.push_back(sm(0, 0, 50, S24)); ex.push_back(mk(50, 0, 1, 0));
    st.push_back(sm(0, 0, 50, S24)); ex.push_back(mk(49, 0, 1, 0));
    st.push_back(sm(0, 0, 50, S24)); ex.push_back(mk(48, 0, 1, 0));
    st.push_back(sm(0, 1, 50, S24)); ex.push_back(mk(0, 0, 0, 1));
    st.push_back(sm(1, 1, 50, S24)); ex.push_back(mk(0, 0, 0, 0));
    st.push_back(sm(1, 1, 50, S24)); ex.push_back(mk(0, 0, 0, 0));
    st.push_back(sm(1, 0, 50, S24)); ex.push_back(mk(50, 1, 0, 0));
    st.push_back(sm(1, 1, 50, S24)); ex.push_back(mk(0, 0, 0, 0));
    st.push_back(sm(1, 0, 60, S24)); ex.push_back(mk(60, 1, 0, 0));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]); exp_q.push_back(ex[i]); tick();
      e = exp_q.pop_front(); o = sample(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL abort[%0d]: got %s, want %s", i, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_step_zero();
    stim_t st[$]; exp_t ex[$]; exp_t e, o;
    st.push_back(sm(1, 0, 500, '0)); ex.push_back(mk(500, 1, 0, 0));
    st.push_back(sm(0, 0, 500, '0)); ex.push_back(mk(500, 0, 1, 0));
    st.push_back(sm(0, 0, 500, '0)); ex.push_back(mk(0, 0, 0, 1));
    st.push_back(sm(0, 0, 500, '0)); ex.push_back(mk(0, 0, 0, 0));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]); exp_q.push_back(ex[i]); tick();
      e = exp_q.pop_front(); o = sample(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL step0[%0d]: got %s, want %s", i, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t st[$]; exp_t ex[$]; exp_t e, o;
    st.push_back(sm(1, 0, -5, S24));  ex.push_back(mk(0, 1, 0, 0));
    st.push_back(sm(0, 0, -5, S24));  ex.push_back(mk(0, 0, 1, 0));
    st.push_back(sm(0, 0, -5, S24));  ex.push_back(mk(0, 0, 0, 1));
    st.push_back(sm(1, 0, 900, S24)); ex.push_back(mk(0, 0, 0, 0));
    st.push_back(sm(1, 0, 900, S24)); ex.push_back(mk(900, 1, 0, 0));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]); exp_q.push_back(ex[i]); tick();
      e = exp_q.pop_front(); o = sample(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL b2b[%0d]: got %s, want %s", i, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e, o;
    drive(sm(0, 0, 60, S24));
    exp_q.push_back(mk(60, 0, 1, 0));
    tick();
    e = exp_q.pop_front(); o = sample(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL arst_ramp0: got %s, want %s", fmt(o), fmt(e));
    end
    exp_q.push_back(mk(59, 0, 1, 0));
    tick();
    e = exp_q.pop_front(); o = sample(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL arst_ramp1: got %s, want %s", fmt(o), fmt(e));
    end
    #2 rst_n = 1'b0;
    #1;
    exp_q.push_back(mk(0, 0, 0, 0));
    e = exp_q.pop_front(); o = sample(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL arst_immediate: got %s, want %s", fmt(o), fmt(e));
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 0));
    tick();
    e = exp_q.pop_front(); o = sample(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL arst_release: got %s, want %s", fmt(o), fmt(e));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, want finish before 100000 ns");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_passthrough();
    test_ramp();
    test_fractional();
    test_restart();
    test_abort();
    test_step_zero();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
